// File: rtl/rr_shared_stage.sv
// Round-robin arbiter that time-multiplexes one registered XOR/AND combining stage
// between N valid/ready requesters. Each result carries the index of its source.
module rr_shared_stage #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*W-1:0]       req_data,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  output logic [W-1:0]         out_data,
  output logic [$clog2(N)-1:0] out_id,
  output logic                 out_valid,
  input  logic                 out_ready
);

  localparam int unsigned IDW = $clog2(N);
  localparam int unsigned HW  = W / 2;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic           v_q, v_d;
  logic [W-1:0]   data_q, data_d;
  logic [IDW-1:0] id_q, id_d;

  logic [W-1:0]   lane [N];
  logic [IDW-1:0] grant;
  logic           any_vld;
  logic           stage_rdy;
  logic           accept;
  logic [W-1:0]   sel;
  logic [HW-1:0]  op_a, op_b;
  int unsigned    idx;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      lane[i] = req_data[i*W +: W];
    end
  end

  // Rotating priority search: first valid requester at or after ptr, wrapping at N
  always_comb begin
    grant   = '0;
    any_vld = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!any_vld && req_valid[idx[IDW-1:0]]) begin
        any_vld = 1'b1;
        grant   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    stage_rdy = out_ready | ~v_q;
    accept    = any_vld & stage_rdy & ~rst;
    sel       = lane[grant];
    op_a      = sel[W-1:HW];
    op_b      = sel[HW-1:0];
  end

  always_comb begin
    ptr_d     = ptr_q;
    v_d       = v_q;
    data_d    = data_q;
    id_d      = id_q;
    req_ready = '0;
    if (accept) begin
      req_ready[grant] = 1'b1;
      data_d           = {op_a ^ op_b, op_a & op_b};
      id_d             = grant;
      v_d              = 1'b1;
      ptr_d            = (grant == IDW'(N - 1)) ? '0 : grant + IDW'(1);
    end else if (v_q && out_ready) begin
      v_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      v_q    <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
    end else begin
      ptr_q  <= ptr_d;
      v_q    <= v_d;
      data_q <= data_d;
      id_q   <= id_d;
    end
  end

  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_valid = v_q;

endmodule

// File: tb/tb_rr_shared_stage.sv
// Bench for rr_shared_stage: directed literal scenarios plus a randomized phase checked
// against a transaction-level model, result scoreboard and fairness bound.
module tb_rr_shared_stage;

  localparam int N   = 4;
  localparam int W   = 2;
  localparam int IDW = $clog2(N);

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_valid;
  logic           out_ready;

  rr_shared_stage #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_data  (req_data),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int fres(input int d);
    int a, b;
    a = d >> (W / 2);
    b = d & ((1 << (W / 2)) - 1);
    return ((a ^ b) << (W / 2)) | (a & b);
  endfunction

  // Transaction-level model state
  int         m_ptr, m_data, m_id, m_g, m_rdy;
  bit         m_v, m_acc, m_known;
  int         wait_cnt [N];
  int         sbq_id[$];
  int         sbq_data[$];
  logic [N-1:0] hs;

  initial begin
    m_known = 1'b0;
    hs      = '0;
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("out_valid", 32'(out_valid), 32'(m_v));
      if (m_v) begin
        chk("out_data", 32'(out_data), m_data);
        chk("out_id", 32'(out_id), m_id);
      end
    end
    if (rst) begin
      chk("req_ready_in_rst", 32'(req_ready), 32'd0);
      m_ptr = 0; m_v = 1'b0; m_data = 0; m_id = 0;
      sbq_id.delete();
      sbq_data.delete();
      for (int i = 0; i < N; i++) wait_cnt[i] = 0;
      hs      = '0;
      m_known = 1'b1;
    end else if (m_known) begin
      m_acc = 1'b0;
      m_g   = 0;
      if (!(m_v && !out_ready)) begin
        for (int k = 0; k < N; k++) begin
          if (!m_acc && req_valid[(m_ptr + k) % N]) begin
            m_acc = 1'b1;
            m_g   = (m_ptr + k) % N;
          end
        end
      end
      m_rdy = m_acc ? (1 << m_g) : 0;
      chk("req_ready", 32'(req_ready), m_rdy);
      hs = req_valid & req_ready;

      if (out_valid && out_ready) begin
        chk("sb_depth", 32'(sbq_id.size()), 32'd1);
        if (sbq_id.size() > 0) begin
          chk("sb_id", 32'(out_id), sbq_id.pop_front());
          chk("sb_data", 32'(out_data), sbq_data.pop_front());
        end
      end

      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || (m_acc && i == m_g)) begin
          wait_cnt[i] = 0;
        end else if (m_acc) begin
          wait_cnt[i]++;
          n_checks++;
          if (wait_cnt[i] > N - 1) begin
            n_err++;
            $display("FAIL fair_wait req %0d waited %0d grants, limit %0d", i, wait_cnt[i], N - 1);
          end
        end
      end

      if (m_acc) begin
        m_data = fres(int'(req_data[m_g*W +: W]));
        m_id   = m_g;
        m_v    = 1'b1;
        m_ptr  = (m_g + 1) % N;
        sbq_id.push_back(m_id);
        sbq_data.push_back(m_data);
      end else if (m_v && out_ready) begin
        m_v = 1'b0;
      end
    end
  end

  // One isolated transfer: request, check grant, then check the registered result
  task automatic step(input logic [N-1:0] v, input logic [N-1:0] exp_rdy, input int exp_id,
                      input int exp_data, input string nm);
    req_valid = v;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(req_ready), 32'(exp_rdy));
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_id"}, 32'(out_id), exp_id);
    chk({nm, "_data"}, 32'(out_data), exp_data);
    @(posedge clk); #1;
  endtask

  logic [W-1:0] exp_out [N];

  initial begin
    exp_out = '{2'b00, 2'b10, 2'b10, 2'b01};
    rst = 1'b1; req_valid = '0; req_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_valid", 32'(out_valid), 32'd0);
    chk("reset_data", 32'(out_data), 32'd0);
    chk("reset_id", 32'(out_id), 32'd0);
    @(posedge clk); #1;

    // Single requester 0 with data 11
    req_data = {2'b00, 2'b00, 2'b00, 2'b11};
    step(4'b0001, 4'b0001, 0, 2'b01, "t1");
    step(4'b0001, 4'b0001, 0, 2'b01, "t1_ptr1_wrap");

    // All valid from a fresh pointer: ids 0,1,2,3,0,1 back to back
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_data  = {2'b11, 2'b10, 2'b01, 2'b00};
    req_valid = 4'b1111;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k > 0) begin
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_id", 32'(out_id), 32'((k - 1) % N));
        chk("t2_data", 32'(out_data), 32'(exp_out[(k - 1) % N]));
      end
      if (k < 6) chk("t2_ready", 32'(req_ready), 32'(1 << (k % N)));
      @(posedge clk); #1;
      if (k == 5) req_valid = '0;
    end

    // Stall with a pending request, then release with no bubble
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t3_ready_pre", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    req_valid = 4'b1000;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t3_stall_ready", 32'(req_ready), 32'd0);
      chk("t3_stall_valid", 32'(out_valid), 32'd1);
      chk("t3_stall_id", 32'(out_id), 32'd2);
      chk("t3_stall_data", 32'(out_data), 32'b10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("t3_nobubble_valid", 32'(out_valid), 32'd1);
    chk("t3_nobubble_id", 32'(out_id), 32'd3);
    chk("t3_nobubble_data", 32'(out_data), 32'b01);
    @(posedge clk); #1;

    // Pointer at 3 skipping to requester 1, then wrap from 3 to 0
    req_data = {2'b11, 2'b10, 2'b10, 2'b00};
    step(4'b0100, 4'b0100, 2, 2'b10, "t4_to_ptr3");
    step(4'b0010, 4'b0010, 1, 2'b10, "t4_grant1");
    step(4'b1100, 4'b0100, 2, 2'b10, "t4_ptr2");
    step(4'b1000, 4'b1000, 3, 2'b01, "t4_grant3");
    step(4'b1111, 4'b0001, 0, 2'b00, "t4_wrap0");

    // Reset while a result is pending and requester 2 waits
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_ready_pre", 32'(req_ready), 32'b0100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_ready_rst", 32'(req_ready), 32'd0);
    chk("t5_valid_before", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    @(negedge clk);
    chk("t5_valid_dropped", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    step(4'b1111, 4'b0001, 0, 2'b00, "t5_ptr0");

    // Randomized traffic: requesters hold valid and data until their handshake
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (hs[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && ($urandom % 3 == 0)) begin
          req_valid[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end
      out_ready = ($urandom % 4) != 0;
      @(posedge clk); #1;
    end

    req_valid = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sbq_id.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
